// File: rtl/sdram_port_responder_if.sv
// sdram_port_responder_if: arbiter-side SDRAM port bundle (request, write data, read beats)
interface sdram_port_responder_if;
    logic [2:0]  sdram_req;
    logic [25:0] sdram_addr;
    logic        sdram_write;
    logic        sdram_burst;
    logic [3:0]  sdram_byte_enable;
    logic [31:0] sdram_wdata;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic [2:0]  sdram_rdvalid;
    logic        sdram_complete;
    modport master (
        output sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
        input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );
    modport slave (
        input  sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
        output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
    );
endinterface

// File: rtl/sdram_port_responder.sv
// sdram_port_responder: BRAM-backed stand-in for the SDRAM controller with latency and refresh stalls
module sdram_port_responder #(
    parameter int MEM_ADDR_BITS    = 14,
    parameter int BURST_LEN        = 16,
    parameter int READ_LATENCY     = 3,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 8
) (
    input logic clock,
    input logic reset,
    sdram_port_responder_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    typedef enum logic [2:0] {IDLE, ACK, LAT, READ, REFRESH} state_t;
    state_t state, nxt;
    logic [31:0] mem [2**MEM_ADDR_BITS];
    logic [MEM_ADDR_BITS-1:0] idx, idx_in;
    logic [2:0] id;
    logic wr;
    logic [BW-1:0] beats;
    logic [7:0] cnt;
    logic [31:0] ref_cnt;
    logic pending, expire, accept;
    assign idx_in = bus.sdram_addr[MEM_ADDR_BITS+1:2];
    assign expire = (REFRESH_INTERVAL != 0) && (ref_cnt == 32'(REFRESH_INTERVAL - 1));
    always_comb begin
        nxt = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (pending) nxt = REFRESH;
                else if (bus.sdram_req != 3'd0) begin
                    nxt = ACK;
                    accept = 1'b1;
                end
            end
            ACK:     nxt = wr ? IDLE : (READ_LATENCY == 1 ? READ : LAT);
            LAT:     nxt = (cnt == 8'(READ_LATENCY - 2)) ? READ : LAT;
            READ:    nxt = (beats == '0) ? IDLE : READ;
            REFRESH: nxt = (cnt == 8'(REFRESH_CYCLES - 1)) ? IDLE : REFRESH;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 8'd0;
            ref_cnt <= 32'd0;
            pending <= 1'b0;
            bus.sdram_ack <= 1'b0;
            bus.sdram_rdata <= 32'd0;
            bus.sdram_rdvalid <= 3'd0;
            bus.sdram_complete <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? 8'd0 : cnt + 8'd1;
            ref_cnt <= expire ? 32'd0 : ref_cnt + 32'd1;
            // an expiry while already pending merges into the same stall
            pending <= expire || (pending && !(state == IDLE && nxt == REFRESH));
            bus.sdram_ack <= nxt == ACK;
            bus.sdram_rdvalid <= (nxt == READ) ? id : 3'd0;
            bus.sdram_rdata <= (nxt == READ) ? mem[idx] : 32'd0;
            bus.sdram_complete <= (nxt == READ) && (beats == BW'(1));
        end
    end
    always_ff @(posedge clock) begin
        if (accept) begin
            id <= bus.sdram_req;
            wr <= bus.sdram_write;
            idx <= idx_in;
            beats <= (bus.sdram_burst && !bus.sdram_write) ? BW'(BURST_LEN) : BW'(1);
        end else if (nxt == READ) begin
            idx <= idx + MEM_ADDR_BITS'(1);
            beats <= beats - BW'(1);
        end
        if (accept && bus.sdram_write && !reset)
            for (int b = 0; b < 4; b++)
                if (bus.sdram_byte_enable[b]) mem[idx_in][8*b +: 8] <= bus.sdram_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_sdram_port_responder.sv
// tb_sdram_port_responder: directed stimulus with a queue scoreboard checked by an independent beat monitor
module tb_sdram_port_responder;
    localparam int AB = 8;
    localparam int LAT = 3;
    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic        last;
        logic        first;
    } beat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sdram_port_responder_if bus();
    sdram_port_responder #(
        .MEM_ADDR_BITS(AB), .BURST_LEN(16), .READ_LATENCY(LAT),
        .REFRESH_INTERVAL(20), .REFRESH_CYCLES(8)
    ) dut (.clock(clk), .reset(rst), .bus(bus));
    beat_t sb[$];
    beat_t e;
    logic [31:0] model [2**AB];
    int checks = 0, fails = 0, cyc = 0, last_ack = -100, last_cmp = -100;
    logic prev_valid = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        if (bus.sdram_ack) last_ack = cyc;
        if (bus.sdram_rdvalid != 3'd0) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat: got id %0d data %h expected no beat", bus.sdram_rdvalid, bus.sdram_rdata);
            end else begin
                e = sb.pop_front();
                check("beat_id", 32'(bus.sdram_rdvalid), 32'(e.id));
                check("beat_data", bus.sdram_rdata, e.data);
                check("beat_complete", 32'(bus.sdram_complete), 32'(e.last));
                if (e.first) check("first_beat_latency", 32'(cyc - last_ack), 32'(LAT));
                else check("beat_contiguous", 32'(prev_valid), 32'd1);
            end
            if (bus.sdram_complete) last_cmp = cyc;
        end else begin
            check("idle_rdata", bus.sdram_rdata, 32'd0);
            check("idle_complete", 32'(bus.sdram_complete), 32'd0);
        end
        prev_valid = bus.sdram_rdvalid != 3'd0;
    end
    task automatic issue(input logic [2:0] id, input logic [25:0] addr, input logic wr, input logic burst,
                         input logic [3:0] be, input logic [31:0] wd, output int ack_cyc);
        bus.sdram_req = id;
        bus.sdram_addr = addr;
        bus.sdram_write = wr;
        bus.sdram_burst = burst;
        bus.sdram_byte_enable = be;
        bus.sdram_wdata = wd;
        ack_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.sdram_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        bus.sdram_req = 3'd0;
        if (ack_cyc < 0) begin
            checks++;
            fails++;
            $display("FAIL ack_timeout: got no ack expected ack for id %0d addr %h", id, addr);
        end
    endtask
    task automatic wr_word(input logic [2:0] id, input logic [25:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output int ack_cyc);
        logic [AB-1:0] w;
        w = addr[AB+1:2];
        for (int b = 0; b < 4; b++) if (be[b]) model[w][8*b +: 8] = wd[8*b +: 8];
        issue(id, addr, 1'b1, 1'b0, be, wd, ack_cyc);
    endtask
    task automatic rd1(input logic [2:0] id, input logic [25:0] addr, input logic [31:0] exp);
        int a;
        sb.push_back('{id: id, data: exp, last: 1'b1, first: 1'b1});
        issue(id, addr, 1'b0, 1'b0, 4'h0, 32'h0, a);
    endtask
    task automatic rdb(input logic [2:0] id, input logic [25:0] addr);
        int a;
        logic [AB-1:0] w;
        w = addr[AB+1:2];
        for (int k = 0; k < 16; k++) begin
            sb.push_back('{id: id, data: model[w], last: k == 15, first: k == 0});
            w = w + AB'(1);
        end
        issue(id, addr, 1'b0, 1'b1, 4'h0, 32'h0, a);
    endtask
    initial begin
        int a, ra, nb, n11, gap;
        int acks[20];
        bus.sdram_req = 3'd0;
        bus.sdram_addr = 26'd0;
        bus.sdram_write = 1'b0;
        bus.sdram_burst = 1'b0;
        bus.sdram_byte_enable = 4'h0;
        bus.sdram_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(bus.sdram_ack), 32'd0);
        check("reset_rdata", bus.sdram_rdata, 32'd0);
        check("reset_rdvalid", 32'(bus.sdram_rdvalid), 32'd0);
        check("reset_complete", 32'(bus.sdram_complete), 32'd0);
        rst = 1'b0;
        wr_word(3'd2, 26'h400, 32'hDEADBEEF, 4'hF, a);
        rd1(3'd2, 26'h400, 32'hDEADBEEF);
        wr_word(3'd1, 26'h40, 32'h11223344, 4'hF, a);
        wr_word(3'd1, 26'h40, 32'hAABBCCDD, 4'b0101, a);
        rd1(3'd1, 26'h40, 32'h11BB33DD);
        wr_word(3'd1, 26'h40, 32'hFFFFFFFF, 4'h0, a);
        rd1(3'd1, 26'h40, 32'h11BB33DD);
        wr_word(3'd5, 26'h3FC, 32'd255, 4'hF, a);
        for (int k = 0; k < 15; k++) wr_word(3'd5, 26'(k * 4), 32'(k), 4'hF, a);
        rdb(3'd5, 26'h3FC);
        for (int i = 0; i < 20; i++) wr_word(3'd4, 26'(32'h80 + i * 4), 32'(32'h1000 + i), 4'hF, acks[i]);
        n11 = 0;
        for (int i = 1; i < 20; i++) begin
            gap = acks[i] - acks[i-1];
            check("ack_gap_2_or_11", 32'(gap == 2 || gap == 11), 32'd1);
            if (gap == 11) n11++;
        end
        check("refresh_stall_seen", 32'(n11 > 0), 32'd1);
        rdb(3'd4, 26'h80);
        sb.push_back('{id: 3'd1, data: 32'h1000, last: 1'b1, first: 1'b1});
        issue(3'd1, 26'h80, 1'b0, 1'b0, 4'h0, 32'h0, ra);
        wr_word(3'd3, 26'h84, 32'h55AA55AA, 4'hF, a);
        check("read_done_before_write_ack", 32'(last_cmp > ra && a > last_cmp), 32'd1);
        rd1(3'd3, 26'h84, 32'h55AA55AA);
        rdb(3'd6, 26'h3FC);
        nb = 0;
        for (int i = 0; i < 100 && nb < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.sdram_rdvalid != 3'd0) nb++;
        end
        check("beats_before_reset", 32'(nb), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rdvalid", 32'(bus.sdram_rdvalid), 32'd0);
        check("abort_complete", 32'(bus.sdram_complete), 32'd0);
        sb.delete();
        rst = 1'b0;
        rd1(3'd6, 26'h40, 32'h11BB33DD);
        rdb(3'd2, 26'h3FC);
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
